// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the select of a 16:1 single-bit mux, with bounded grant
// length, a one-cycle dead gap between grants, and a registered sample of the mux output.
module mux16_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic [15:0] mask,
  input  logic        mux_out,
  output logic [3:0]  sel,
  output logic [15:0] grant,
  output logic        valid,
  output logic        data_q,
  output logic [3:0]  data_ch,
  output logic        data_valid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  hold_q, hold_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] elig;
  logic [3:0]  winner;
  logic [3:0]  idx;
  logic        found;
  logic        keep;

  assign elig = req & ~mask;

  // First eligible channel scanning upward from ptr, wrapping 15 -> 0.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = '0;
    for (int i = 0; i < 16; i++) begin
      idx = ptr_q + 4'(i);
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign keep = req[sel_q] && !mask[sel_q] && (hold_q < 4'(MAX_HOLD));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    sel_d   = sel_q;
    case (state_q)
      ST_GRANT: begin
        if (keep) begin
          hold_d = hold_q + 4'd1;
        end else begin
          state_d = ST_GAP;
          ptr_d   = sel_q + 4'd1;
        end
      end
      default: begin
        // IDLE and GAP arbitrate identically.
        if (found) begin
          state_d = ST_GRANT;
          sel_d   = winner;
          hold_d  = 4'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= 1'b0;
      data_ch    <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= valid;
      if (valid) begin
        data_q  <= mux_out;
        data_ch <= sel_q;
      end
    end
  end

  assign valid = (state_q == ST_GRANT);
  assign sel   = sel_q;
  assign grant = valid ? (16'(1) << sel_q) : '0;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Randomised bench for mux16_rr_arbiter against a channel-ownership reference model.
module tb_mux16_rr_arbiter;

  localparam int unsigned MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req, mask, mux_a;
  logic        mux_out;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        valid, data_q, data_valid;
  logic [3:0]  data_ch;

  int n_checks = 0;
  int n_fail   = 0;
  int vcount   = 0;

  // Model: which channel owns the mux (-1 none), for how long, and the rotation start.
  int          m_owner, m_len, m_ptr;
  logic [3:0]  m_sel, m_dch;
  logic        m_dq, m_dv;

  always #5 clk = ~clk;

  assign mux_out = mux_a[sel];

  mux16_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mask       (mask),
    .mux_out    (mux_out),
    .sel        (sel),
    .grant      (grant),
    .valid      (valid),
    .data_q     (data_q),
    .data_ch    (data_ch),
    .data_valid (data_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_len   = 0;
    m_ptr   = 0;
    m_sel   = '0;
    m_dq    = 1'b0;
    m_dch   = '0;
    m_dv    = 1'b0;
  endtask

  task automatic check_outputs();
    logic [15:0] exp_grant;
    exp_grant = '0;
    if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
    check("valid", 32'(valid), 32'(m_owner >= 0));
    check("grant", 32'(grant), 32'(exp_grant));
    check("sel", 32'(sel), 32'(m_sel));
    check("data_valid", 32'(data_valid), 32'(m_dv));
    check("data_q", 32'(data_q), 32'(m_dq));
    check("data_ch", 32'(data_ch), 32'(m_dch));
    if (valid) vcount++;
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_step();
    logic [15:0] elig;
    int          c;
    bit          found;
    elig = req & ~mask;
    m_dv = (m_owner >= 0);
    if (m_dv) begin
      m_dq  = mux_a[m_sel];
      m_dch = m_sel;
    end
    if (m_owner >= 0) begin
      if (req[m_owner] && !mask[m_owner] && m_len < int'(MAX_HOLD)) begin
        m_len++;
      end else begin
        m_ptr   = (m_owner + 1) % 16;
        m_owner = -1;
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < 16; k++) begin
        c = (m_ptr + k) % 16;
        if (!found && elig[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_len   = 1;
          m_sel   = 4'(c);
        end
      end
    end
  endtask

  // mode 0: hold inputs; 1: random every cycle; 2: mask ch6 mid-grant;
  // 3: drop req after 2 grant cycles of ch3; 4: slowly changing random
  task automatic drive(input int mode);
    case (mode)
      1: begin
        req  = 16'($urandom);
        mask = 16'($urandom & $urandom & $urandom);
        if ($urandom_range(0, 9) == 0) mux_a = 16'($urandom);
      end
      2: if (m_owner == 6 && m_len == 3) mask[6] = 1'b1;
      3: if (m_owner == 3 && m_len == 2) req = '0;
      4: begin
        if ($urandom_range(0, 7) == 0) req  = 16'($urandom) & 16'($urandom);
        if ($urandom_range(0, 15) == 0) mask = 16'($urandom & $urandom);
        mux_a = 16'($urandom);
      end
      default: ;
    endcase
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
      drive(mode);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    mask  = '0;
    mux_a = '0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run(4, 0);

    // Single requester re-granted after each gap.
    req   = 16'h0010;
    mux_a = 16'($urandom);
    run(60, 0);

    // Full rotation with the alternating-bit mux pattern.
    req   = 16'hFFFF;
    mux_a = 16'haaaa;
    run(16 * (MAX_HOLD + 1) + 12, 0);

    // Odd channels masked, then ch6 masked part-way through its grant.
    mask = 16'hAAAA;
    run(8 * (MAX_HOLD + 1) * 2, 2);

    req  = '0;
    mask = '0;
    run(MAX_HOLD + 4, 0);

    // Early release: exactly two valid cycles.
    req    = 16'h0008;
    vcount = 0;
    run(20, 3);
    check("early_valid_cycles", 32'(vcount), 32'd2);

    run(300, 1);
    run(300, 4);

    // Asynchronous reset mid-grant.
    req  = 16'hFFFF;
    mask = '0;
    run(13, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(2, 0);
    check("post_reset_first_grant", 32'(grant), 32'h0001);
    run(40, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
